// File: rtl/dual_rail_mixcol_seq_if.sv
// Handshake and dual-rail data bundle between ShiftRows, the MixColumns engine
// and AddRoundKey.
interface dual_rail_mixcol_seq_if #(
  parameter int N = 128
);
  // A block moves on a rising edge where valid && ready are both 1; valid must
  // stay high and data stable until that edge, and ready may not wait on valid.
  logic         In_Valid;
  logic         In_Ready;
  logic         In_Inv;
  logic [N-1:0] MixCol_In_T;
  logic [N-1:0] MixCol_In_F;
  logic         Out_Valid;
  logic         Out_Ready;
  logic [N-1:0] MixCol_Out_T;
  logic [N-1:0] MixCol_Out_F;
  logic         Err;

  modport master (
    output In_Valid, In_Inv, MixCol_In_T, MixCol_In_F, Out_Ready,
    input  In_Ready, Out_Valid, MixCol_Out_T, MixCol_Out_F, Err
  );

  modport slave (
    input  In_Valid, In_Inv, MixCol_In_T, MixCol_In_F, Out_Ready,
    output In_Ready, Out_Valid, MixCol_Out_T, MixCol_Out_F, Err
  );
endinterface

// File: rtl/dual_rail_mixcol_seq.sv
// Sequential dual-rail MixColumns/InvMixColumns engine: alternates precharge and
// evaluate phases, COLS_PER_CYCLE columns per evaluate, with a sticky rail error.
module dual_rail_mixcol_seq #(
  parameter int N              = 128,
  parameter int NB             = 4,
  parameter int COLS_PER_CYCLE = 1,
  parameter int INV_EN         = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  dual_rail_mixcol_seq_if.slave          bus,
  output logic [1:0]                     dbg_state,
  output logic [COLS_PER_CYCLE*32-1:0]   dbg_res_t,
  output logic [COLS_PER_CYCLE*32-1:0]   dbg_res_f
);

  localparam int          CW       = $clog2(NB + 1);
  localparam int          RW       = COLS_PER_CYCLE * 32;
  localparam logic        INV_OK   = (INV_EN != 0);
  localparam logic [7:0]  POLY     = 8'h1b;
  localparam logic [15:0] FWD_COEF = 16'h2311;
  localparam logic [15:0] INV_COEF = 16'hebd9;

  typedef enum logic [1:0] {IDLE = 2'd0, PRE = 2'd1, EVAL = 2'd2, DONE = 2'd3} state_t;

  typedef struct packed {
    logic [7:0] t;
    logic [7:0] f;
  } dr8_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    in_t_q, in_t_d, in_f_q, in_f_d;
  logic            inv_q, inv_d;
  logic [RW-1:0]   res_t_q, res_t_d, res_f_q, res_f_d;
  logic [N-1:0]    out_t_q, out_t_d, out_f_q, out_f_d;
  logic            err_q, err_d;
  logic [RW-1:0]   eval_t, eval_f;
  logic [N-1:0]    bad_in;

  function automatic dr8_t dr_xor(input dr8_t a, input dr8_t b);
    dr8_t r;
    r.t = (a.t & b.f) | (a.f & b.t);
    r.f = (a.t & b.t) | (a.f & b.f);
    return r;
  endfunction

  // Bit-7 rails choose, on the polynomial bits only, between the plain shift
  // and its rail-swapped copy (xor 0x1b).
  function automatic dr8_t dr_xtime(input dr8_t a);
    dr8_t s, r;
    s.t = {a.t[6:0], 1'b0};
    s.f = {a.f[6:0], 1'b1};
    r.t = (~POLY & s.t) | (POLY & (({8{a.t[7]}} & s.f) | ({8{a.f[7]}} & s.t)));
    r.f = (~POLY & s.f) | (POLY & (({8{a.t[7]}} & s.t) | ({8{a.f[7]}} & s.f)));
    return r;
  endfunction

  function automatic dr8_t dr_mul(input dr8_t a, input logic [3:0] k);
    dr8_t acc, p;
    acc.t = '0;
    acc.f = '1;
    p     = a;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) acc = dr_xor(acc, p);
      p = dr_xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [63:0] mix_col(input logic [31:0] ct, input logic [31:0] cf,
                                          input logic inv);
    dr8_t        a [4];
    dr8_t        o;
    logic [31:0] rt, rf;
    logic [3:0]  k;
    rt = '0;
    rf = '0;
    for (int r = 0; r < 4; r++) begin
      a[r].t = ct[31-r*8 -: 8];
      a[r].f = cf[31-r*8 -: 8];
    end
    for (int r = 0; r < 4; r++) begin
      o.t = '0;
      o.f = '1;
      for (int j = 0; j < 4; j++) begin
        k = inv ? INV_COEF[15-j*4 -: 4] : FWD_COEF[15-j*4 -: 4];
        o = dr_xor(o, dr_mul(a[(r+j)%4], k));
      end
      rt[31-r*8 -: 8] = o.t;
      rf[31-r*8 -: 8] = o.f;
    end
    return {rt, rf};
  endfunction

  assign bad_in = ~(bus.MixCol_In_T ^ bus.MixCol_In_F);

  always_comb begin
    int          base;
    logic [63:0] col;
    eval_t = '0;
    eval_f = '0;
    base   = 0;
    col    = '0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      base = N - 1 - (((int'(cnt_q) + j) % NB) * 32);
      col  = mix_col(in_t_q[base -: 32], in_f_q[base -: 32], inv_q);
      eval_t[RW-1-j*32 -: 32] = col[63:32];
      eval_f[RW-1-j*32 -: 32] = col[31:0];
    end
  end

  always_comb begin
    int base;
    state_d = state_q;
    cnt_d   = cnt_q;
    in_t_d  = in_t_q;
    in_f_d  = in_f_q;
    inv_d   = inv_q;
    res_t_d = res_t_q;
    res_f_d = res_f_q;
    out_t_d = out_t_q;
    out_f_d = out_f_q;
    err_d   = err_q;
    base    = 0;
    case (state_q)
      IDLE: begin
        if (bus.In_Valid) begin
          // Bad bits are stored as their T-rail value so the block still computes.
          in_t_d  = bus.MixCol_In_T;
          in_f_d  = (bus.MixCol_In_F & ~bad_in) | (~bus.MixCol_In_T & bad_in);
          inv_d   = bus.In_Inv & INV_OK;
          cnt_d   = '0;
          res_t_d = '0;
          res_f_d = '0;
          err_d   = err_q | (|bad_in);
          state_d = PRE;
        end
      end
      PRE: begin
        res_t_d = '0;
        res_f_d = '0;
        // A trailing precharge after the last group returns the result register to spacer.
        if (cnt_q == CW'(NB)) begin
          state_d = DONE;
        end else begin
          res_t_d = eval_t;
          res_f_d = eval_f;
          state_d = EVAL;
        end
      end
      EVAL: begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          base = N - 1 - (((int'(cnt_q) + j) % NB) * 32);
          out_t_d[base -: 32] = res_t_q[RW-1-j*32 -: 32];
          out_f_d[base -: 32] = res_f_q[RW-1-j*32 -: 32];
        end
        err_d   = err_q | (|(~(res_t_q ^ res_f_q)));
        res_t_d = '0;
        res_f_d = '0;
        cnt_d   = cnt_q + CW'(COLS_PER_CYCLE);
        state_d = PRE;
      end
      DONE: begin
        if (bus.Out_Ready) begin
          out_t_d = '0;
          out_f_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      in_t_q  <= '0;
      in_f_q  <= '0;
      inv_q   <= 1'b0;
      res_t_q <= '0;
      res_f_q <= '0;
      out_t_q <= '0;
      out_f_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      in_t_q  <= in_t_d;
      in_f_q  <= in_f_d;
      inv_q   <= inv_d;
      res_t_q <= res_t_d;
      res_f_q <= res_f_d;
      out_t_q <= out_t_d;
      out_f_q <= out_f_d;
      err_q   <= err_d;
    end
  end

  assign bus.In_Ready     = (state_q == IDLE);
  assign bus.Out_Valid    = (state_q == DONE);
  assign bus.MixCol_Out_T = (state_q == DONE) ? out_t_q : '0;
  assign bus.MixCol_Out_F = (state_q == DONE) ? out_f_q : '0;
  assign bus.Err          = err_q;
  assign dbg_state        = state_q;
  assign dbg_res_t        = res_t_q;
  assign dbg_res_f        = res_f_q;

endmodule

// File: tb/tb_dual_rail_mixcol_seq.sv
// Bench for dual_rail_mixcol_seq: directed vectors, random blocks against a GF(2^8)
// reference model, back-pressure, rail-error injection and mid-block reset.
module tb_dual_rail_mixcol_seq;
  localparam int N   = 128;
  localparam int LAT = 9;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  dbg_state;
  logic [31:0] dbg_res_t, dbg_res_f;
  int          cyc      = 0;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic        exp_err  = 1'b0;
  logic [N-1:0] exp_q[$];

  dual_rail_mixcol_seq_if #(.N(N)) bus ();

  dual_rail_mixcol_seq #(.N(N), .NB(4), .COLS_PER_CYCLE(1), .INV_EN(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_res_t (dbg_res_t),
    .dbg_res_f (dbg_res_f)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // reference model
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [N-1:0] ref_mix(input logic [N-1:0] s, input logic inv);
    logic [7:0]   cf [4];
    logic [7:0]   acc;
    logic [N-1:0] o;
    if (inv) begin
      cf[0] = 8'h0e; cf[1] = 8'h0b; cf[2] = 8'h0d; cf[3] = 8'h09;
    end else begin
      cf[0] = 8'h02; cf[1] = 8'h03; cf[2] = 8'h01; cf[3] = 8'h01;
    end
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(cf[j], s[N-1-c*32-((r+j)%4)*8 -: 8]);
        o[N-1-c*32-r*8 -: 8] = acc;
      end
    return o;
  endfunction

  // precharge monitor
  always @(negedge clk) begin
    if (dbg_state == 2'd1) begin
      check("pre_res_t", 128'(dbg_res_t), 128'(0));
      check("pre_res_f", 128'(dbg_res_f), 128'(0));
    end
    if (!bus.Out_Valid)
      check("idle_out_spacer", bus.MixCol_Out_T | bus.MixCol_Out_F, '0);
  end

  // driver tasks
  task automatic reset_dut();
    rst_n         = 1'b0;
    bus.In_Valid  = 1'b0;
    bus.In_Inv    = 1'b0;
    bus.MixCol_In_T = '0;
    bus.MixCol_In_F = '0;
    bus.Out_Ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 128'(bus.In_Ready), 128'(1));
    check("rst_out_valid", 128'(bus.Out_Valid), 128'(0));
    check("rst_err", 128'(bus.Err), 128'(0));
    check("rst_state", 128'(dbg_state), 128'(0));
    check("rst_res", 128'(dbg_res_t | dbg_res_f), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_err = 1'b0;
  endtask

  task automatic send(input logic [N-1:0] t, input logic [N-1:0] f, input logic inv,
                      input logic [N-1:0] exp, output int acc);
    int w;
    w = 0;
    @(negedge clk);
    while (!bus.In_Ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("accept_wait", 128'(w < 50), 128'(1));
    bus.In_Valid    = 1'b1;
    bus.In_Inv      = inv;
    bus.MixCol_In_T = t;
    bus.MixCol_In_F = f;
    @(posedge clk);
    #1;
    acc = cyc;
    exp_q.push_back(exp);
    check("err_after_accept", 128'(bus.Err), 128'(exp_err));
    // scramble inputs: they must be ignored while busy
    bus.In_Valid    = 1'($urandom_range(0, 1));
    bus.In_Inv      = 1'($urandom_range(0, 1));
    bus.MixCol_In_T = {$urandom, $urandom, $urandom, $urandom};
    bus.MixCol_In_F = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic recv(input int acc, input int hold);
    int           w;
    logic [N-1:0] exp, held_t, held_f;
    w = 0;
    @(negedge clk);
    while (!bus.Out_Valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("out_valid_wait", 128'(w < 40), 128'(1));
    check("latency", 128'(cyc - acc), 128'(LAT));
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check("out_t", bus.MixCol_Out_T, exp);
    check("out_f", bus.MixCol_Out_F, ~exp);
    check("done_in_ready", 128'(bus.In_Ready), 128'(0));
    check("err", 128'(bus.Err), 128'(exp_err));
    held_t = bus.MixCol_Out_T;
    held_f = bus.MixCol_Out_F;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_t", bus.MixCol_Out_T, held_t);
      check("hold_f", bus.MixCol_Out_F, held_f);
      check("hold_valid", 128'(bus.Out_Valid), 128'(1));
      check("hold_in_ready", 128'(bus.In_Ready), 128'(0));
    end
    bus.Out_Ready = 1'b1;
    bus.In_Valid  = 1'b0;
    @(negedge clk);
    bus.Out_Ready = 1'b0;
    check("handoff_valid", 128'(bus.Out_Valid), 128'(0));
    check("handoff_spacer", bus.MixCol_Out_T | bus.MixCol_Out_F, '0);
    check("handoff_in_ready", 128'(bus.In_Ready), 128'(1));
  endtask

  task automatic run_block(input logic [N-1:0] t, input logic inv,
                           input logic [N-1:0] exp, input int hold);
    int acc;
    send(t, ~t, inv, exp, acc);
    recv(acc, hold);
  endtask

  logic [N-1:0] ones_cols, vec_a, vec_b, vec_c, vec_d, rnd, bad_t, bad_f;
  logic         rinv;
  int           acc_r;

  initial begin
    ones_cols = {32'h01010101, 32'h01010101, 32'h01010101};
    vec_a = {32'hdb135345, ones_cols[95:0]};
    vec_b = {32'h8e4da1bc, ones_cols[95:0]};
    vec_c = {32'hf20a225c, ones_cols[95:0]};
    vec_d = {32'h9fdc589d, ones_cols[95:0]};

    reset_dut();

    // directed vectors
    run_block(vec_a, 1'b0, vec_b, 0);
    run_block(vec_b, 1'b1, vec_a, 0);
    run_block(vec_c, 1'b0, vec_d, 5);
    run_block(vec_d, 1'b1, vec_c, 1);

    // random blocks vs model
    for (int i = 0; i < 12; i++) begin
      rnd  = {$urandom, $urandom, $urandom, $urandom};
      rinv = 1'($urandom_range(0, 1));
      run_block(rnd, rinv, ref_mix(rnd, rinv), $urandom_range(0, 3));
    end

    // rail error on bit 0 (T=F=1): computes as 1, Err sticky
    bad_t    = {$urandom, $urandom, $urandom, $urandom};
    bad_t[0] = 1'b1;
    bad_f    = ~bad_t;
    bad_f[0] = 1'b1;
    exp_err  = 1'b1;
    send(bad_t, bad_f, 1'b0, ref_mix(bad_t, 1'b0), acc_r);
    recv(acc_r, 0);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_block(rnd, 1'b1, ref_mix(rnd, 1'b1), 2);

    // reset during the third EVAL
    rnd = {$urandom, $urandom, $urandom, $urandom};
    send(rnd, ~rnd, 1'b0, ref_mix(rnd, 1'b0), acc_r);
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("third_eval_state", 128'(dbg_state), 128'(2));
    rst_n = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk);
    check("midrst_state", 128'(dbg_state), 128'(0));
    check("midrst_out_valid", 128'(bus.Out_Valid), 128'(0));
    check("midrst_spacer", bus.MixCol_Out_T | bus.MixCol_Out_F, '0);
    check("midrst_in_ready", 128'(bus.In_Ready), 128'(1));
    check("midrst_err", 128'(bus.Err), 128'(0));
    bus.In_Valid = 1'b0;
    rst_n   = 1'b1;
    exp_err = 1'b0;
    rnd = {$urandom, $urandom, $urandom, $urandom};
    run_block(rnd, 1'b0, ref_mix(rnd, 1'b0), 0);
    run_block(vec_a, 1'b0, vec_b, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
